// File: rtl/booth_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package  : booth_pkg                                               |
// | Brief    : Shared constants, FSM state encoding and sign-extend    |
// |            helper for the Booth multiplier / MAC datapath.         |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package booth_pkg;

   // Default datapath geometry for the multiplier-to-accumulator path.
   localparam int BOOTH_PROD_W    = 8;
   localparam int BOOTH_ACC_W     = 16;
   localparam int BOOTH_MAX_TERMS = 16;

   // Accumulator FSM encoding.
   localparam int         ST_W     = 2;
   localparam logic [1:0] ST_IDLE  = 2'd0;  // no term of the current frame taken
   localparam logic [1:0] ST_ACCUM = 2'd1;  // at least one term taken
   localparam logic [1:0] ST_HOLD  = 2'd2;  // frame result presented downstream

   // Sign-extend the low 'width' bits of 'value' to 32 bits. Callers
   // truncate the result to their own width, so any width up to 32 works.
   function automatic logic [31:0] sign_extend(input logic [31:0] value, input int width);
      logic [31:0] shifted;
      shifted = value << (32 - width);
      return 32'($signed(shifted) >>> (32 - width));
   endfunction

endpackage
`default_nettype wire

// File: rtl/booth_mac_accumulator_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface: booth_mac_accumulator_if                                |
// | Brief    : Product-in / frame-result-out handshake bundle of the   |
// |            Booth MAC accumulator.                                  |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
interface booth_mac_accumulator_if
   import booth_pkg::*;
#(
   parameter int PROD_W    = BOOTH_PROD_W,
   parameter int ACC_W     = BOOTH_ACC_W,
   parameter int MAX_TERMS = BOOTH_MAX_TERMS
);
   localparam int CNT_W = $clog2(MAX_TERMS + 1);

   // Product stream from the multiplier
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] in_product;
   logic              in_last;

   // Frame result towards writeback / host readout
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_acc;
   logic [CNT_W-1:0]  out_count;
   logic              out_sat;

   // Producer of products and consumer of results
   modport master (
      output in_valid, in_product, in_last, out_ready,
      input  in_ready, out_valid, out_acc, out_count, out_sat
   );

   // The accumulator stage itself
   modport slave (
      input  in_valid, in_product, in_last, out_ready,
      output in_ready, out_valid, out_acc, out_count, out_sat
   );

endinterface
`default_nettype wire

// File: rtl/booth_sat_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : booth_sat_adder                                         |
// | Brief    : Combinational signed adder that clamps to the most      |
// |            positive / most negative value and flags overflow.      |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module booth_sat_adder
   import booth_pkg::*;
#(
   parameter int ACC_W = BOOTH_ACC_W
)(
   input  logic [ACC_W-1:0] i_a,
   input  logic [ACC_W-1:0] i_b,
   output logic [ACC_W-1:0] o_sum,
   output logic             o_ovf
);
   localparam logic [ACC_W-1:0] c_pos_max = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] c_neg_min = {1'b1, {(ACC_W-1){1'b0}}};

   logic [ACC_W-1:0] w_raw;

   assign w_raw = i_a + i_b;

   // Two's-complement overflow: operands agree in sign but the result does not.
   assign o_ovf = (i_a[ACC_W-1] == i_b[ACC_W-1]) && (w_raw[ACC_W-1] != i_a[ACC_W-1]);

   // Clamp towards the side the operands were heading on overflow.
   always_comb begin
      o_sum = w_raw;
      if (o_ovf) begin
         o_sum = i_a[ACC_W-1] ? c_neg_min : c_pos_max;
      end
   end

endmodule
`default_nettype wire

// File: rtl/booth_mac_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : booth_mac_accumulator                                   |
// | Brief    : Saturating signed dot-product accumulator behind the    |
// |            Booth multiplier; frames close on in_last or on the     |
// |            term limit and the result is offered valid/ready.       |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module booth_mac_accumulator
   import booth_pkg::*;
#(
   parameter int PROD_W    = BOOTH_PROD_W,
   parameter int ACC_W     = BOOTH_ACC_W,     // up to 32 bits
   parameter int MAX_TERMS = BOOTH_MAX_TERMS
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   booth_mac_accumulator_if.slave  bus
);
   localparam int                 CNT_W      = $clog2(MAX_TERMS + 1);
   localparam logic [CNT_W-1:0]   c_last_cnt = CNT_W'(MAX_TERMS - 1);
   localparam logic [CNT_W-1:0]   c_cnt_one  = CNT_W'(1);

   logic [ST_W-1:0]  r_state;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_count;
   logic             r_sat;

   logic [ACC_W-1:0] w_ext;
   logic [ACC_W-1:0] w_sum;
   logic             w_ovf;
   logic             w_in_ready;
   logic             w_accept;
   logic             w_close;
   logic             w_valid;

   // Product sign-extended to accumulator width.
   assign w_ext = ACC_W'(sign_extend(32'(bus.in_product), PROD_W));

   booth_sat_adder #(
      .ACC_W (ACC_W)
   ) u_sat_adder (
      .i_a   (r_acc),
      .i_b   (w_ext),
      .o_sum (w_sum),
      .o_ovf (w_ovf)
   );

   // Nothing is taken while a result is pending or while the frame is being
   // aborted, so clear never races an accept.
   assign w_in_ready = (r_state != ST_HOLD) && !clear;
   assign w_accept   = bus.in_valid && w_in_ready;

   // A frame closes on an explicit last term or when this term fills it.
   assign w_close    = bus.in_last || (r_count == c_last_cnt);

   assign w_valid    = (r_state == ST_HOLD);

   // Frame FSM plus accumulator, term counter and sticky saturation flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_acc   <= '0;
         r_count <= '0;
         r_sat   <= 1'b0;
      end else if (clear) begin
         r_state <= ST_IDLE;
         r_acc   <= '0;
         r_count <= '0;
         r_sat   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_ACCUM: begin
               if (w_accept) begin
                  r_acc   <= w_sum;
                  r_count <= r_count + c_cnt_one;
                  r_sat   <= r_sat | w_ovf;
                  r_state <= w_close ? ST_HOLD : ST_ACCUM;
               end
            end
            ST_HOLD: begin
               if (bus.out_ready) begin
                  r_state <= ST_IDLE;
                  r_acc   <= '0;
                  r_count <= '0;
                  r_sat   <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_acc   <= '0;
               r_count <= '0;
               r_sat   <= 1'b0;
            end
         endcase
      end
   end

   // Result fields read as zero whenever no result is being offered, so a
   // partial sum is never visible downstream.
   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_valid;
   assign bus.out_acc   = w_valid ? r_acc   : '0;
   assign bus.out_count = w_valid ? r_count : '0;
   assign bus.out_sat   = w_valid & r_sat;

endmodule
`default_nettype wire

// File: tb/tb_booth_mac_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_booth_mac_accumulator                                |
// | Brief    : Three accumulator builds (16-bit/16 terms, 8-bit/16     |
// |            terms, 16-bit/4 terms) driven in lockstep and checked   |
// |            against a frame-level integer model.                    |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_booth_mac_accumulator;
   import booth_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear;
   logic       in_valid;
   logic [7:0] in_product;
   logic       in_last;
   logic       out_ready;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   booth_mac_accumulator_if #(.PROD_W(8), .ACC_W(16), .MAX_TERMS(16)) bus_a ();
   booth_mac_accumulator_if #(.PROD_W(8), .ACC_W(8),  .MAX_TERMS(16)) bus_b ();
   booth_mac_accumulator_if #(.PROD_W(8), .ACC_W(16), .MAX_TERMS(4))  bus_c ();

   assign bus_a.in_valid = in_valid;  assign bus_a.in_product = in_product;
   assign bus_a.in_last  = in_last;   assign bus_a.out_ready  = out_ready;
   assign bus_b.in_valid = in_valid;  assign bus_b.in_product = in_product;
   assign bus_b.in_last  = in_last;   assign bus_b.out_ready  = out_ready;
   assign bus_c.in_valid = in_valid;  assign bus_c.in_product = in_product;
   assign bus_c.in_last  = in_last;   assign bus_c.out_ready  = out_ready;

   booth_mac_accumulator #(.PROD_W(8), .ACC_W(16), .MAX_TERMS(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_a));
   booth_mac_accumulator #(.PROD_W(8), .ACC_W(8), .MAX_TERMS(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_b));
   booth_mac_accumulator #(.PROD_W(8), .ACC_W(16), .MAX_TERMS(4)) dut_c (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_c));

   // Reference model: one frame per build, kept as plain integers.
   int    m_aw [3] = '{16, 8, 16};
   int    m_mt [3] = '{16, 16, 4};
   string m_nm [3] = '{"a16", "b8", "c4"};
   bit    m_hold [3];
   int    m_acc  [3];
   int    m_cnt  [3];
   bit    m_sat  [3];

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_hold[k] = 1'b0; m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 1'b0;
      end
   endtask

   // Advance every model by one clock edge with the inputs currently applied.
   task automatic model_step();
      for (int k = 0; k < 3; k++) begin
         int hi;
         int lo;
         int sum;
         hi = (1 << (m_aw[k] - 1)) - 1;
         lo = -(1 << (m_aw[k] - 1));
         if (clear) begin
            m_hold[k] = 1'b0; m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 1'b0;
         end else if (m_hold[k]) begin
            if (out_ready) begin
               m_hold[k] = 1'b0; m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 1'b0;
            end
         end else if (in_valid) begin
            sum = m_acc[k] + int'($signed(in_product));
            if (sum > hi) begin sum = hi; m_sat[k] = 1'b1; end
            if (sum < lo) begin sum = lo; m_sat[k] = 1'b1; end
            m_acc[k] = sum;
            m_cnt[k] = m_cnt[k] + 1;
            if (in_last || m_cnt[k] == m_mt[k]) m_hold[k] = 1'b1;
         end
      end
   endtask

   task automatic check_one(input int k, input logic rdy, input logic vld,
                            input logic signed [31:0] acc, input logic [31:0] cnt,
                            input logic sat);
      logic              e_rdy;
      logic              e_vld;
      logic signed [31:0] e_acc;
      logic [31:0]       e_cnt;
      logic              e_sat;
      e_rdy = !m_hold[k] && !clear;
      e_vld = m_hold[k];
      e_acc = m_hold[k] ? m_acc[k] : 0;
      e_cnt = m_hold[k] ? m_cnt[k] : 0;
      e_sat = m_hold[k] && m_sat[k];
      n_vec++;
      assert (rdy === e_rdy) else begin
         n_err++; $error("FAIL %s in_ready: got %0b want %0b", m_nm[k], rdy, e_rdy);
      end
      n_vec++;
      assert (vld === e_vld) else begin
         n_err++; $error("FAIL %s out_valid: got %0b want %0b", m_nm[k], vld, e_vld);
      end
      n_vec++;
      assert (acc === e_acc) else begin
         n_err++; $error("FAIL %s out_acc: got %0d want %0d", m_nm[k], acc, e_acc);
      end
      n_vec++;
      assert (cnt === e_cnt) else begin
         n_err++; $error("FAIL %s out_count: got %0d want %0d", m_nm[k], cnt, e_cnt);
      end
      n_vec++;
      assert (sat === e_sat) else begin
         n_err++; $error("FAIL %s out_sat: got %0b want %0b", m_nm[k], sat, e_sat);
      end
   endtask

   task automatic check_all();
      check_one(0, bus_a.in_ready, bus_a.out_valid, $signed(bus_a.out_acc), 32'(bus_a.out_count), bus_a.out_sat);
      check_one(1, bus_b.in_ready, bus_b.out_valid, $signed(bus_b.out_acc), 32'(bus_b.out_count), bus_b.out_sat);
      check_one(2, bus_c.in_ready, bus_c.out_valid, $signed(bus_c.out_acc), 32'(bus_c.out_count), bus_c.out_sat);
   endtask

   // Directed spot check of one observed value against a hand-derived constant.
   task automatic expect_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] want);
      n_vec++;
      assert (got === want) else begin
         n_err++; $error("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   // One clock: apply inputs, take the edge, advance the model, compare after the edge.
   task automatic cyc(input bit v, input logic [7:0] p, input bit l, input bit r, input bit c);
      in_valid = v; in_product = p; in_last = l; out_ready = r; clear = c;
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic async_reset_pulse();
      in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #2;
      check_all();
      expect_val("rst_async a out_valid", 32'(bus_a.out_valid), 0);
      expect_val("rst_async a out_acc", $signed(bus_a.out_acc), 0);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_product = '0;
      in_last = 1'b0; out_ready = 1'b0;
      model_reset();
      #12;
      check_all();
      rst_n = 1'b1;
      cyc(0, 8'd0, 0, 1, 0);

      // Test 1: 6, -3, 10(last)
      cyc(1, 8'd6, 0, 1, 0);
      cyc(1, 8'hFD, 0, 1, 0);
      cyc(1, 8'd10, 1, 1, 0);
      expect_val("t1 a out_valid", 32'(bus_a.out_valid), 1);
      expect_val("t1 a out_acc", $signed(bus_a.out_acc), 13);
      expect_val("t1 a out_count", 32'(bus_a.out_count), 3);
      expect_val("t1 a out_sat", 32'(bus_a.out_sat), 0);
      cyc(0, 8'd0, 0, 1, 0);
      expect_val("t1 a in_ready after handoff", 32'(bus_a.in_ready), 1);

      // Test 2: saturation on the 8-bit build
      cyc(1, 8'd100, 0, 1, 0);
      cyc(1, 8'd100, 1, 1, 0);
      expect_val("t2 b pos clamp", $signed(bus_b.out_acc), 127);
      expect_val("t2 b pos sat", 32'(bus_b.out_sat), 1);
      expect_val("t2 a no clamp", $signed(bus_a.out_acc), 200);
      cyc(0, 8'd0, 0, 1, 0);
      cyc(1, 8'h80, 0, 1, 0);
      cyc(1, 8'h80, 0, 1, 0);
      cyc(1, 8'hFF, 1, 1, 0);
      expect_val("t2 b neg clamp", $signed(bus_b.out_acc), -128);
      expect_val("t2 b neg sat", 32'(bus_b.out_sat), 1);
      expect_val("t2 b count", 32'(bus_b.out_count), 3);
      cyc(0, 8'd0, 0, 1, 0);

      // Test 3: term limit on the 4-term build, fifth term must wait
      repeat (4) cyc(1, 8'd49, 0, 0, 0);
      expect_val("t3 c out_acc", $signed(bus_c.out_acc), 196);
      expect_val("t3 c out_count", 32'(bus_c.out_count), 4);
      repeat (2) cyc(1, 8'd49, 0, 0, 0);
      expect_val("t3 c in_ready", 32'(bus_c.in_ready), 0);
      expect_val("t3 c held acc", $signed(bus_c.out_acc), 196);
      cyc(0, 8'd0, 0, 0, 1);
      cyc(0, 8'd0, 0, 0, 0);

      // Test 4: back-pressure in HOLD
      cyc(1, 8'd1, 0, 0, 0);
      cyc(1, 8'd2, 1, 0, 0);
      repeat (5) begin
         cyc(0, 8'd0, 0, 0, 0);
         expect_val("t4 a held acc", $signed(bus_a.out_acc), 3);
         expect_val("t4 a in_ready", 32'(bus_a.in_ready), 0);
      end
      cyc(0, 8'd0, 0, 1, 0);
      expect_val("t4 a in_ready release", 32'(bus_a.in_ready), 1);
      expect_val("t4 a acc cleared", $signed(bus_a.out_acc), 0);

      // Test 5: abort with clear, then a fresh single-term frame
      cyc(1, 8'd7, 0, 1, 0);
      cyc(1, 8'd8, 0, 1, 0);
      cyc(0, 8'd0, 0, 1, 1);
      expect_val("t5 a no valid", 32'(bus_a.out_valid), 0);
      cyc(1, 8'd5, 1, 1, 0);
      expect_val("t5 a out_acc", $signed(bus_a.out_acc), 5);
      expect_val("t5 a out_count", 32'(bus_a.out_count), 1);
      cyc(0, 8'd0, 0, 1, 0);

      // Test 6: async reset mid-ACCUM and mid-HOLD
      cyc(1, 8'd3, 0, 1, 0);
      cyc(1, 8'd4, 0, 1, 0);
      async_reset_pulse();
      cyc(1, 8'd9, 1, 0, 0);
      cyc(0, 8'd0, 0, 0, 0);
      async_reset_pulse();
      cyc(1, 8'd11, 1, 1, 0);
      expect_val("t6 a out_acc", $signed(bus_a.out_acc), 11);
      expect_val("t6 a out_count", 32'(bus_a.out_count), 1);
      cyc(0, 8'd0, 0, 1, 0);

      // Randomized traffic against the model
      repeat (400) begin
         cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
